// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central hazard sequencer for a five-stage pipeline. Detects load-use
//   hazards, taken-branch flushes and data-memory wait states. Drives the
//   per-stage stall/flush controls and the operand forwarding selects. Also
//   keeps stall/flush performance counters and a sticky memory-timeout flag.
//
// Ports:
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   ID_rs1/2, ID_rs1/2_used  source operands of the instruction in ID
//   EX_*, MEM_*, WB_*        destination info from the later stage registers
//   mem_req, mem_ready       DRAM handshake of the MEM stage
//   *_stall / *_flush        combinational pipeline register controls
//   fwd_rs1_sel/fwd_rs2_sel  00 regfile, 01 EX, 10 MEM, 11 WB
//   mem_err                  sticky memory-timeout flag
//   stall_cnt, flush_cnt     performance counters (one cycle behind)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter logic [1:0] WD_DRAM = 2'b01,
  parameter int         TIMEOUT = 16,
  parameter int         CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_rs1_used,
  input  logic             ID_rs2_used,
  input  logic             EX_rf_we,
  input  logic [4:0]       EX_wR,
  input  logic [1:0]       EX_wd_sel,
  input  logic             EX_br_taken,
  input  logic             MEM_rf_we,
  input  logic [4:0]       MEM_wR,
  input  logic             WB_rf_we,
  input  logic [4:0]       WB_wR,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_flush,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t              state_reg, state_next;
  logic [WAIT_W-1:0]   wait_reg, wait_next, wait_inc;
  logic                err_reg, err_next;
  logic [CNT_W-1:0]    stall_cnt_reg, flush_cnt_reg;
  logic                br_fire;
  logic                load_use, mem_stall, ex_is_load, run_eval;

  assign ex_is_load = (EX_wd_sel == WD_DRAM);
  assign load_use   = EX_rf_we & ex_is_load & (EX_wR != 5'd0) &
                      ((ID_rs1_used & (ID_rs1 == EX_wR)) |
                       (ID_rs2_used & (ID_rs2 == EX_wR)));
  assign mem_stall  = mem_req & ~mem_ready;
  assign wait_inc   = wait_reg + 1'b1;

  // Branch/load-use arbitration applies in RUN when memory is not stalling,
  // and in the MEM_WAIT cycle where the DRAM data arrives.
  assign run_eval = ((state_reg == RUN) & ~mem_stall) |
                    ((state_reg == MEM_WAIT) & mem_ready);

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    memwb_flush = 1'b0;
    br_fire     = 1'b0;
    state_next  = state_reg;
    wait_next   = wait_reg;
    err_next    = err_reg;

    if (run_eval) begin
      state_next = RUN;
      wait_next  = '0;
      if (EX_br_taken) begin
        // A taken branch squashes the younger instruction, so any load-use
        // against it is moot.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        br_fire    = 1'b1;
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end else begin
      // Memory stall: freeze everything up to EX/MEM, bubble into MEM/WB.
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_flush = 1'b1;
      if (state_reg == RUN) begin
        state_next = MEM_WAIT;
        wait_next  = WAIT_W'(1);
      end else begin
        wait_next = wait_inc;
        if (wait_inc >= WAIT_W'(TIMEOUT)) begin
          err_next   = 1'b1;
          state_next = RUN;
          wait_next  = '0;
        end
      end
    end

    // Hold the pipeline in a clean bubble state while reset is asserted.
    if (!rst_n) begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_stall  = 1'b0;
      exmem_stall = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      br_fire     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      wait_reg      <= '0;
      err_reg       <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      err_reg   <= err_next;
      if (pc_stall) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (br_fire)  flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign mem_err   = err_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

  // Forwarding, one identical selector per source operand.
  logic [4:0] op_reg [2];
  logic [1:0] op_sel [2];

  assign op_reg[0]   = ID_rs1;
  assign op_reg[1]   = ID_rs2;
  assign fwd_rs1_sel = op_sel[0];
  assign fwd_rs2_sel = op_sel[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic nz, ex_hit, mem_hit, wb_hit;
      assign nz      = (op_reg[gi] != 5'd0);
      // A load in EX has no result yet; load_use covers that case.
      assign ex_hit  = nz & EX_rf_we & (EX_wR == op_reg[gi]) & ~ex_is_load;
      assign mem_hit = nz & MEM_rf_we & (MEM_wR == op_reg[gi]);
      assign wb_hit  = nz & WB_rf_we & (WB_wR == op_reg[gi]);
      always_comb begin
        op_sel[gi] = 2'b00;
        if (!rst_n)       op_sel[gi] = 2'b00;
        else if (ex_hit)  op_sel[gi] = 2'b01;
        else if (mem_hit) op_sel[gi] = 2'b10;
        else if (wb_hit)  op_sel[gi] = 2'b11;
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed scoreboard bench: each cycle the expected control vector and
//   forwarding selects are queued when the inputs are driven, then popped and
//   compared once the combinational outputs settle. Counters and mem_err are
//   checked after every edge against bench-side expectations.
//   Control vector bit order:
//   {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
//    memwb_flush}
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_MEM  = 7'b1101011;
  localparam logic [6:0] C_BR   = 7'b0010100;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_RST  = 7'b0010101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ID_rs1, ID_rs2;
  logic        ID_rs1_used, ID_rs2_used;
  logic        EX_rf_we;
  logic [4:0]  EX_wR;
  logic [1:0]  EX_wd_sel;
  logic        EX_br_taken;
  logic        MEM_rf_we;
  logic [4:0]  MEM_wR;
  logic        WB_rf_we;
  logic [4:0]  WB_wR;
  logic        mem_req, mem_ready;
  logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic        exmem_stall, memwb_flush;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic        mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.WD_DRAM(2'b01), .TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .EX_rf_we(EX_rf_we), .EX_wR(EX_wR), .EX_wd_sel(EX_wd_sel),
    .EX_br_taken(EX_br_taken),
    .MEM_rf_we(MEM_rf_we), .MEM_wR(MEM_wR),
    .WB_rf_we(WB_rf_we), .WB_wR(WB_wR),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush),
    .exmem_stall(exmem_stall), .memwb_flush(memwb_flush),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [6:0] ctrl;
    logic [1:0] f1;
    logic [1:0] f2;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_flush = 0;
  logic        exp_err   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic clr();
    ID_rs1 = 0; ID_rs2 = 0; ID_rs1_used = 0; ID_rs2_used = 0;
    EX_rf_we = 0; EX_wR = 0; EX_wd_sel = 0; EX_br_taken = 0;
    MEM_rf_we = 0; MEM_wR = 0; WB_rf_we = 0; WB_wR = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  // One transaction: inputs already driven at the falling edge.
  task automatic cycle(input string tag, input logic [6:0] ctrl,
                       input logic [1:0] f1, input logic [1:0] f2);
    exp_t e;
    exp_t got;
    e.tag = tag; e.ctrl = ctrl; e.f1 = f1; e.f2 = f2;
    exp_q.push_back(e);
    #2;
    got = exp_q.pop_front();
    check_val({got.tag, ".ctrl"},
              {25'd0, pc_stall, ifid_stall, ifid_flush, idex_stall,
               idex_flush, exmem_stall, memwb_flush}, {25'd0, got.ctrl});
    check_val({got.tag, ".fwd1"}, {30'd0, fwd_rs1_sel}, {30'd0, got.f1});
    check_val({got.tag, ".fwd2"}, {30'd0, fwd_rs2_sel}, {30'd0, got.f2});
    @(posedge clk);
    if (!rst_n) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (got.ctrl[6]) exp_stall = exp_stall + 1;
      if (got.ctrl == C_BR) exp_flush = exp_flush + 1;
    end
    @(negedge clk);
    check_val({got.tag, ".stall_cnt"}, stall_cnt, exp_stall);
    check_val({got.tag, ".flush_cnt"}, flush_cnt, exp_flush);
    check_val({got.tag, ".mem_err"}, {31'd0, mem_err}, {31'd0, exp_err});
    $display("txn %-12s ctrl=%b fwd=%b/%b stall_cnt=%0d flush_cnt=%0d err=%b",
             got.tag, got.ctrl, got.f1, got.f2, stall_cnt, flush_cnt, mem_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst_n = 1'b0;
    @(negedge clk);

    // Reset: flushes high, stalls low, forwarding forced to 00.
    MEM_rf_we = 1; MEM_wR = 5'd3; ID_rs1 = 5'd3;
    cycle("rst", C_RST, 2'b00, 2'b00);
    clr();
    cycle("rst2", C_RST, 2'b00, 2'b00);
    rst_n = 1'b1;

    // 1. load-use on rs1, then MEM and WB forwarding of the load result.
    clr(); EX_rf_we = 1; EX_wR = 5; EX_wd_sel = 2'b01; ID_rs1 = 5; ID_rs1_used = 1;
    cycle("lu", C_LU, 2'b00, 2'b00);
    clr(); MEM_rf_we = 1; MEM_wR = 5; ID_rs1 = 5; ID_rs1_used = 1;
    cycle("lu_fwd_mem", C_NONE, 2'b10, 2'b00);
    clr(); WB_rf_we = 1; WB_wR = 5; ID_rs1 = 5; ID_rs1_used = 1;
    cycle("fwd_wb", C_NONE, 2'b11, 2'b00);
    // Load match on an unused operand is not a hazard, and EX load never forwards.
    clr(); EX_rf_we = 1; EX_wR = 6; EX_wd_sel = 2'b01; ID_rs2 = 6;
    cycle("lu_unused", C_NONE, 2'b00, 2'b00);
    // Load to x0 never stalls.
    clr(); EX_rf_we = 1; EX_wR = 0; EX_wd_sel = 2'b01; ID_rs1_used = 1;
    cycle("lu_x0", C_NONE, 2'b00, 2'b00);

    // 2. EX beats MEM; register 0 never forwards.
    clr(); EX_rf_we = 1; EX_wR = 7; MEM_rf_we = 1; MEM_wR = 7;
    ID_rs2 = 7; ID_rs2_used = 1;
    cycle("fwd_ex", C_NONE, 2'b00, 2'b01);
    clr(); EX_rf_we = 1; MEM_rf_we = 1; WB_rf_we = 1; ID_rs2_used = 1;
    cycle("fwd_x0", C_NONE, 2'b00, 2'b00);
    clr(); MEM_rf_we = 1; MEM_wR = 9; WB_rf_we = 1; WB_wR = 9; ID_rs1 = 9; ID_rs2 = 9;
    cycle("fwd_mem_wb", C_NONE, 2'b10, 2'b10);

    // 3. Three wait cycles then ready; branch/load-use ignored while waiting.
    clr(); mem_req = 1;
    cycle("mw1", C_MEM, 2'b00, 2'b00);
    EX_br_taken = 1;
    cycle("mw2_br", C_MEM, 2'b00, 2'b00);
    EX_br_taken = 0; EX_rf_we = 1; EX_wR = 4; EX_wd_sel = 2'b01;
    ID_rs1 = 4; ID_rs1_used = 1;
    cycle("mw3_lu", C_MEM, 2'b00, 2'b00);
    clr(); mem_req = 1; mem_ready = 1;
    cycle("mw_ready", C_NONE, 2'b00, 2'b00);
    clr();
    cycle("run_idle", C_NONE, 2'b00, 2'b00);
    // Wait then ready cycle carrying a taken branch.
    mem_req = 1;
    cycle("mw_b1", C_MEM, 2'b00, 2'b00);
    mem_ready = 1; EX_br_taken = 1;
    cycle("mw_b_ready", C_BR, 2'b00, 2'b00);

    // 4. Taken branch overrides load-use.
    clr(); EX_br_taken = 1; EX_rf_we = 1; EX_wR = 5; EX_wd_sel = 2'b01;
    ID_rs2 = 5; ID_rs2_used = 1;
    cycle("br_lu", C_BR, 2'b00, 2'b00);

    // 5. Timeout after 16 stalled cycles; mem_err sticky.
    clr(); mem_req = 1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) exp_err = 1'b1;
      cycle($sformatf("to%0d", i), C_MEM, 2'b00, 2'b00);
    end
    cycle("to_rerun", C_MEM, 2'b00, 2'b00);
    mem_req = 0; mem_ready = 1;
    cycle("to_ready", C_NONE, 2'b00, 2'b00);
    clr();
    cycle("err_sticky", C_NONE, 2'b00, 2'b00);

    // 6. Reset while in MEM_WAIT.
    mem_req = 1;
    cycle("pre_rst1", C_MEM, 2'b00, 2'b00);
    cycle("pre_rst2", C_MEM, 2'b00, 2'b00);
    rst_n = 1'b0; exp_err = 1'b0;
    MEM_rf_we = 1; MEM_wR = 3; ID_rs1 = 3;
    EX_br_taken = 1;
    cycle("rst_mw", C_RST, 2'b00, 2'b00);
    rst_n = 1'b1;
    clr();
    cycle("post_rst", C_NONE, 2'b00, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
